// File: rtl/tiny_ram_pkg.sv
// Shared types and defaults for the two-port RAM arbiter: FSM states,
// transaction owner ID and default bus widths.
package tiny_ram_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    // One-hot grant vector {b, a} to owner ID; an empty grant maps to A.
    function automatic owner_t owner_of(input logic [1:0] gnt);
        owner_t owner;
        if (gnt[1]) begin
            owner = OWNER_B;
        end else begin
            owner = OWNER_A;
        end
        return owner;
    endfunction

endpackage

// File: rtl/tiny_ram_arbiter_if.sv
// Requester-side and RAM-side signals of the tiny RAM arbiter, bundled.
// The arbiter is the slave; the requesters and the RAM sit on the master side.
interface tiny_ram_arbiter_if #(
    parameter int AW = tiny_ram_pkg::DEF_AW,
    parameter int DW = tiny_ram_pkg::DEF_DW
);

    logic          req_a;
    logic          req_b;
    logic          we_a;
    logic          we_b;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_a;
    logic [DW-1:0] wdata_b;
    logic          gnt_a;
    logic          gnt_b;
    logic          done_a;
    logic          done_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic [AW-1:0] ram_wraddress;
    logic [AW-1:0] ram_rdaddress;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  ram_q,
        output gnt_a, gnt_b, done_a, done_b, rdata_a, rdata_b,
        output ram_wraddress, ram_rdaddress, ram_data, ram_wren
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output ram_q,
        input  gnt_a, gnt_b, done_a, done_b, rdata_a, rdata_b,
        input  ram_wraddress, ram_rdaddress, ram_data, ram_wren
    );

endinterface

// File: rtl/tiny_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant {b, a} while enabled, and a
// pointer that favours the side not granted last (A after reset).
module tiny_rr_arbiter (
    input  logic       clock,
    input  logic       aclr,
    input  logic       i_enable,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_prio_b;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_enable) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_prio_b ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end else begin
            w_gnt = 2'b00;
        end
    end

    // Pointer moves only when something is actually granted.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_prio_b <= 1'b0;
        end else if (w_gnt != 2'b00) begin
            r_prio_b <= w_gnt[0];
        end else begin
            r_prio_b <= r_prio_b;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/tiny_ram_arbiter.sv
// Serialises two requesters onto one combinational-read RAM: IDLE grants,
// ACCESS writes or reads the RAM, DONE pulses the owner's completion.
module tiny_ram_arbiter
    import tiny_ram_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic              clock,
    input  logic              aclr,
    tiny_ram_arbiter_if.slave io_bus
);

    state_t        r_state;
    state_t        w_next_state;
    owner_t        r_owner;
    owner_t        w_gnt_owner;
    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_arb_en;
    logic          w_any_gnt;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          r_we;
    logic          r_wren;
    logic          r_done_a;
    logic          r_done_b;
    logic [AW-1:0] r_wraddress;
    logic [AW-1:0] r_rdaddress;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_rdata_a;
    logic [DW-1:0] r_rdata_b;

    assign w_req    = {io_bus.req_b, io_bus.req_a};
    // Grants are blocked while reset is held, even though the state reads IDLE.
    assign w_arb_en = (r_state == IDLE) && !aclr;

    tiny_rr_arbiter u_rr (
        .clock    (clock),
        .aclr     (aclr),
        .i_enable (w_arb_en),
        .i_req    (w_req),
        .o_gnt    (w_gnt)
    );

    assign w_any_gnt   = |w_gnt;
    assign w_gnt_owner = owner_of(w_gnt);

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = {AW{1'b0}};
        w_sel_wdata = {DW{1'b0}};
        if (w_gnt_owner == OWNER_B) begin
            w_sel_we    = io_bus.we_b;
            w_sel_addr  = io_bus.addr_b;
            w_sel_wdata = io_bus.wdata_b;
        end else begin
            w_sel_we    = io_bus.we_a;
            w_sel_addr  = io_bus.addr_a;
            w_sel_wdata = io_bus.wdata_a;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_gnt) begin
                    w_next_state = ACCESS;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS:  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Granted request is latched and held on the RAM pins until the next grant.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_owner     <= OWNER_A;
            r_we        <= 1'b0;
            r_wraddress <= {AW{1'b0}};
            r_rdaddress <= {AW{1'b0}};
            r_data      <= {DW{1'b0}};
        end else if (w_any_gnt) begin
            r_owner     <= w_gnt_owner;
            r_we        <= w_sel_we;
            r_wraddress <= w_sel_addr;
            r_rdaddress <= w_sel_addr;
            r_data      <= w_sel_wdata;
        end else begin
            r_owner     <= r_owner;
            r_we        <= r_we;
            r_wraddress <= r_wraddress;
            r_rdaddress <= r_rdaddress;
            r_data      <= r_data;
        end
    end

    // Grants only happen in IDLE, so wren is high for exactly the ACCESS cycle.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_wren   <= 1'b0;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
        end else begin
            r_wren   <= w_any_gnt & w_sel_we;
            r_done_a <= (r_state == ACCESS) && (r_owner == OWNER_A);
            r_done_b <= (r_state == ACCESS) && (r_owner == OWNER_B);
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_rdata_a <= {DW{1'b0}};
            r_rdata_b <= {DW{1'b0}};
        end else if ((r_state == ACCESS) && !r_we) begin
            if (r_owner == OWNER_B) begin
                r_rdata_b <= io_bus.ram_q;
            end else begin
                r_rdata_a <= io_bus.ram_q;
            end
        end else begin
            r_rdata_a <= r_rdata_a;
            r_rdata_b <= r_rdata_b;
        end
    end

    assign io_bus.gnt_a         = w_gnt[0];
    assign io_bus.gnt_b         = w_gnt[1];
    assign io_bus.done_a        = r_done_a;
    assign io_bus.done_b        = r_done_b;
    assign io_bus.rdata_a       = r_rdata_a;
    assign io_bus.rdata_b       = r_rdata_b;
    assign io_bus.ram_wraddress = r_wraddress;
    assign io_bus.ram_rdaddress = r_rdaddress;
    assign io_bus.ram_data      = r_data;
    assign io_bus.ram_wren      = r_wren;

endmodule

// File: doc/tiny_ram_arbiter.md
TINY_RAM_ARBITER -- requirements
Module: tiny_ram_arbiter

Interface
REQ-001 Parameter DW, default 4: data width; SHALL match the RAM data width.
REQ-002 Parameter AW, default 4: address width; SHALL match the RAM address width (16 words).
REQ-003 clock  input  1: single clock; all state changes on its rising edge.
REQ-004 aclr  input  1: reset; asynchronous, active-high.
REQ-005 req_a, req_b  input  1 each: requester A/B access request; level, held until granted.
REQ-006 we_a, we_b  input  1 each: 1 = write, 0 = read; sampled with req in the grant cycle.
REQ-007 addr_a, addr_b  input  AW each: word address.
REQ-008 wdata_a, wdata_b  input  DW each: write data.
REQ-009 gnt_a, gnt_b  output  1 each: request accepted this cycle; combinational from req and state.
REQ-010 done_a, done_b  output  1 each: one-cycle completion pulse, for both reads and writes.
REQ-011 rdata_a, rdata_b  output  DW each: read data, valid while the matching done pulse is high with we=0.
REQ-012 ram_wraddress, ram_rdaddress  output  AW each; ram_data  output  DW; ram_wren  output  1: registered drives to the shared RAM.
REQ-013 ram_q  input  DW: RAM read data; combinational from ram_rdaddress (no RAM clock).

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, DONE; IDLE->ACCESS on any grant, ACCESS->DONE always, DONE->IDLE always; 3 cycles per transaction.
REQ-015 gnt_a/gnt_b SHALL assert only in IDLE; at most one high in any cycle.
REQ-016 Single requester in IDLE SHALL be granted in the same cycle (cycle N).
REQ-017 Both requesting in IDLE: grant the requester not granted last (round-robin); pointer updates only on a grant.
REQ-018 On grant (end of N): addr, we, wdata and owner ID SHALL be registered; ram_wraddress, ram_rdaddress and ram_data SHALL take the granted values and hold them through DONE.
REQ-019 ACCESS (N+1): ram_wren = registered we; ram_wren SHALL be 0 in every other state.
REQ-020 End of ACCESS: ram_q SHALL be captured into the owner's rdata register for a read; the other requester's rdata SHALL hold.
REQ-021 DONE (N+2): owner's done pulse high one cycle; no grant in DONE; earliest next grant at N+3.
REQ-022 req changes in ACCESS/DONE SHALL have no effect until IDLE; a request dropped before grant is not served.
REQ-023 Write then read of the same address by any requesters SHALL return the written data (strictly serialized).

Reset
REQ-024 aclr high: state=IDLE, round-robin pointer favours A first, ram_wren=0, all gnt/done=0, rdata_a/rdata_b=0, RAM address/data regs=0, immediately (no clock).
REQ-025 aclr asserted mid-ACCESS: ram_wren SHALL drop asynchronously; the transaction is discarded with no done pulse; the RAM contents are not restored.
REQ-026 First grant is possible in the first clock edge after aclr deasserts.

Structure
REQ-027 Shared package tiny_ram_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), the owner ID type, and default AW/DW constants.
REQ-028 A single sub-module tiny_rr_arbiter (2-way round-robin, req in, one-hot gnt out, pointer reg) SHALL be used; the FSM and datapath regs live in the top level.
REQ-029 The block SHALL instantiate nothing else; the RAM is connected at the parent level.

Verification
REQ-030 Reset: aclr=1 with req_a=1 -> gnt_a=0, ram_wren=0, rdata_a=rdata_b=0; after release, gnt_a=1 on the first edge.
REQ-031 Write/read A: write addr 3 data 0xA, then read addr 3 -> ram_wren high exactly 1 cycle at N+1, done_a at N+2 both times, rdata_a=0xA.
REQ-032 Contention: req_a and req_b held continuously, reads of addr 1 and 2 -> grants alternate A,B,A,B every 3 cycles, starting with A; no double grant.
REQ-033 Cross-port coherency: B writes addr 15 data 0x5, A reads addr 15 -> rdata_a=0x5; rdata_b unchanged.
REQ-034 Reset mid-op: aclr in ACCESS of a write to addr 7 -> ram_wren=0 at once, no done_a, state IDLE after release.
REQ-035 Late request: req_b rises during A's ACCESS -> gnt_b not before A's transaction returns to IDLE (N+3).
